// File: rtl/serial_pattern_source.sv
// Valid/ready word in, one bit per en strobe out on J; first bit at least one edge after accept; din_ready = hold empty.
// A single holding register gives gap-free back-to-back words. Define SERIAL_PATTERN_PARITY_EN to append an even-parity bit.
module serial_pattern_source #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             J,
    output logic             J_valid,
    output logic             word_done,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

`ifdef SERIAL_PATTERN_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS);
    localparam logic [CW-1:0] LOAD_CNT = CW'(NBITS - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;
    logic [CW-1:0]      r_cnt;
    logic               r_j;
    logic               r_jv;
    logic               r_done;
    logic [CNT_W-1:0]   r_words;
`ifdef SERIAL_PATTERN_PARITY_EN
    logic               r_par;
`endif

    logic               w_accept;
    logic               w_last;
    logic               w_load;
    logic               w_first;
    logic               w_next;
    logic [WIDTH-1:0]   w_hold_adv;
    logic [WIDTH-1:0]   w_shift_adv;

    assign w_accept    = din_valid & ~r_hold_full;
    assign w_last      = (r_state == S_SHIFT) & (r_cnt == '0);
    assign w_load      = en & r_hold_full & ((r_state == S_IDLE) | w_last);
    assign w_first     = (MSB_FIRST != 0) ? r_hold[WIDTH-1]  : r_hold[0];
    assign w_next      = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
    assign w_hold_adv  = (MSB_FIRST != 0) ? (r_hold << 1)  : (r_hold >> 1);
    assign w_shift_adv = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
            r_j         <= 1'b0;
            r_jv        <= 1'b0;
            r_done      <= 1'b0;
            r_words     <= '0;
`ifdef SERIAL_PATTERN_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            // Accept only when hold is empty, so a transfer always sees the old word.
            if (w_accept) begin
                r_hold      <= din;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (en) begin
                if (w_last)
                    r_words <= r_words + 1'b1;

                if (w_load) begin
                    r_state <= S_SHIFT;
                    r_shift <= w_hold_adv;
                    r_j     <= w_first;
                    r_cnt   <= LOAD_CNT;
                    r_jv    <= 1'b1;
                    r_done  <= 1'b0;
`ifdef SERIAL_PATTERN_PARITY_EN
                    r_par   <= ^r_hold;
`endif
                end else if ((r_state == S_SHIFT) && (r_cnt != '0)) begin
                    r_cnt   <= r_cnt - 1'b1;
                    r_done  <= (r_cnt == CW'(1));
                    r_shift <= w_shift_adv;
`ifdef SERIAL_PATTERN_PARITY_EN
                    r_j     <= (r_cnt == CW'(1)) ? r_par : w_next;
`else
                    r_j     <= w_next;
`endif
                end else if (r_state == S_SHIFT) begin
                    r_state <= S_IDLE;
                    r_j     <= 1'b0;
                    r_jv    <= 1'b0;
                    r_done  <= 1'b0;
                end
            end
        end
    end

    assign din_ready  = ~r_hold_full;
    assign busy       = (r_state == S_SHIFT) | r_hold_full;
    assign J          = r_j;
    assign J_valid    = r_jv;
    assign word_done  = r_done;
    assign words_sent = r_words;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Bench for serial_pattern_source: bit-stream queue model checked every cycle plus literal stream expectations.
module tb_serial_pattern_source;
    localparam int W   = 8;
    localparam int MSB = 1;
    localparam int CW  = 16;
`ifdef SERIAL_PATTERN_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L = W + PAR;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0;
    logic          en = 1'b1;
    logic          din_ready, J, J_valid, word_done, busy;
    logic [CW-1:0] words_sent;

    always #5 clk = ~clk;

    serial_pattern_source #(.WIDTH(W), .MSB_FIRST(MSB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .en(en), .J(J), .J_valid(J_valid), .word_done(word_done), .busy(busy),
        .words_sent(words_sent)
    );

    // Model: queue of bits still to be shown, plus the bit currently on J.
    typedef struct packed { logic b; logic last; } mbit_t;
    mbit_t       q[$];
    mbit_t       m_e;
    logic        m_acc;
    logic        cur_b = 1'b0, cur_last = 1'b0, cur_v = 1'b0, en_edge = 1'b0;
    int unsigned m_words = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            cur_v = 1'b0; cur_b = 1'b0; cur_last = 1'b0; en_edge = 1'b0; m_words = 0;
        end else begin
            m_acc   = din_valid && (q.size() < L);
            en_edge = en;
            if (en) begin
                if (cur_v && cur_last) m_words++;
                if (q.size() > 0) begin
                    m_e = q.pop_front();
                    cur_b = m_e.b; cur_last = m_e.last; cur_v = 1'b1;
                end else begin
                    cur_v = 1'b0;
                end
            end
            if (m_acc) begin
                for (int i = 0; i < W; i++) begin
                    m_e.b    = din[(MSB != 0) ? (W - 1 - i) : i];
                    m_e.last = (PAR == 0) && (i == W - 1);
                    q.push_back(m_e);
                end
                if (PAR != 0) begin
                    m_e.b = ^din; m_e.last = 1'b1;
                    q.push_back(m_e);
                end
            end
        end
    end

    int         errors = 0;
    int         checks = 0;
    logic       rec[$];
    int         tot_valid = 0, n_rise = 0, n_det = 0, det_len = 0;
    logic [4:0] det = '0;
    logic       prev_jv = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    task automatic tick();
        @(negedge clk);
        chk("J",          {31'd0, J},          {31'd0, cur_v ? cur_b : 1'b0});
        chk("J_valid",    {31'd0, J_valid},    {31'd0, cur_v});
        chk("word_done",  {31'd0, word_done},  {31'd0, cur_v && cur_last});
        chk("din_ready",  {31'd0, din_ready},  {31'd0, q.size() < L});
        chk("busy",       {31'd0, busy},       {31'd0, cur_v || (q.size() >= L)});
        chk("words_sent", {16'd0, words_sent}, {16'd0, m_words[15:0]});
        if (J_valid) begin
            tot_valid++;
            if (!prev_jv) n_rise++;
            if (en_edge) begin
                rec.push_back(J);
                det = {det[3:0], J};
                det_len++;
                if (det_len >= 5 && det == 5'b10010) n_det++;
            end
        end else begin
            det_len = 0;
        end
        prev_jv = J_valid;
    endtask

    function automatic logic [31:0] get_rec(input int s);
        logic [31:0] v = '0;
        for (int i = s; i < rec.size(); i++) v = {v[30:0], rec[i]};
        return v;
    endfunction

    task automatic send_word(input logic [W-1:0] w);
        logic r;
        logic ok = 1'b0;
        din = w;
        din_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            r = din_ready;
            tick();
            if (r) begin ok = 1'b1; break; end
        end
        din_valid = 1'b0;
        if (!ok) fail_timeout("accept");
    endtask

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (!busy && !J_valid) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) fail_timeout("idle");
    endtask

    task automatic wait_bits(input int s, input int n);
        logic ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (rec.size() - s >= n) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) fail_timeout("bits");
    endtask

    initial begin
        int s, v, r, d;
        // Reset held from time 0.
        repeat (3) tick();
        chk("rst_J_valid", {31'd0, J_valid},   32'd0);
        chk("rst_ready",   {31'd0, din_ready}, 32'd1);
        chk("rst_busy",    {31'd0, busy},      32'd0);
        rst = 1'b1;
        tick();

        // Single word 1001_0000.
        s = rec.size(); v = tot_valid;
        send_word(8'b1001_0000);
        wait_idle();
        chk("single_stream", get_rec(s), (PAR != 0) ? 32'h120 : 32'h90);
        chk("single_valid",  tot_valid - v, L);
        chk("single_words",  {16'd0, words_sent}, 32'd1);

        // Back-to-back A5, 3C: one continuous valid run.
        s = rec.size(); v = tot_valid; r = n_rise; d = n_det;
        send_word(8'hA5);
        send_word(8'h3C);
        wait_idle();
        chk("b2b_stream", get_rec(s), (PAR != 0) ? 32'h29478 : 32'hA53C);
        chk("b2b_valid",  tot_valid - v, 2 * L);
        chk("b2b_runs",   n_rise - r, 1);
        chk("b2b_det",    n_det - d, 1);
        chk("b2b_words",  {16'd0, words_sent}, 32'd3);

        // Stall for 3 cycles while bit 4 of F0 is on J.
        s = rec.size(); v = tot_valid;
        send_word(8'hF0);
        wait_bits(s, 4);
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        wait_idle();
        chk("stall_stream", get_rec(s), (PAR != 0) ? 32'h1E0 : 32'hF0);
        chk("stall_valid",  tot_valid - v, L + 3);
        chk("stall_words",  {16'd0, words_sent}, 32'd4);

        // Word 01: parity bit is 1 when enabled.
        s = rec.size();
        send_word(8'h01);
        wait_idle();
        chk("w01_stream", get_rec(s), (PAR != 0) ? 32'h3 : 32'h1);
        chk("w01_words",  {16'd0, words_sent}, 32'd5);

        // Reset mid-word with a word waiting in hold.
        s = rec.size();
        send_word(8'hFF);
        send_word(8'h81);
        wait_bits(s, 3);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_J",       {31'd0, J},          32'd0);
        chk("arst_J_valid", {31'd0, J_valid},    32'd0);
        chk("arst_ready",   {31'd0, din_ready},  32'd1);
        chk("arst_busy",    {31'd0, busy},       32'd0);
        chk("arst_words",   {16'd0, words_sent}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("post_rst_J_valid", {31'd0, J_valid},   32'd0);
        chk("post_rst_ready",   {31'd0, din_ready}, 32'd1);
        s = rec.size();
        send_word(8'h5A);
        wait_idle();
        chk("post_rst_stream", get_rec(s), (PAR != 0) ? 32'hB4 : 32'h5A);
        chk("post_rst_words",  {16'd0, words_sent}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/serial_pattern_source.md
Name: serial_pattern_source

Overview:
- Parallel-to-serial stage feeding the serial sequence detectors (e.g. the 10010 Mealy detector's J input).
- Accepts WIDTH-bit words through a valid/ready handshake and emits them one bit per enabled clock on J, with a J_valid qualifier.
- A single-entry holding register allows back-to-back words with no idle bit between them.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.
- CNT_W, 16, width of the words_sent counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (rst=0 resets).
- din  input  WIDTH  word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block can accept a word this cycle.
- en  input  1  bit-advance strobe; shifter advances only when en=1.
- J  output  1  registered serial bit.
- J_valid  output  1  J carries a data bit this cycle.
- word_done  output  1  one-cycle pulse on the cycle the last bit of a word is on J.
- busy  output  1  shifter active or holding register full.
- words_sent  output  CNT_W  count of completed words; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, J=0, J_valid=0, word_done=0, holding register empty, bit counter 0, words_sent=0, din_ready=1, busy=0.
- din_ready = holding register empty. It is driven from registered state only; there is no combinational path from din_valid.
- Accept: a word is accepted on a rising edge when din_valid=1 and din_ready=1; din is captured into the holding register. Acceptance is independent of en.
- State machine:
  - IDLE: J_valid=0, J=0.
  - SHIFT: J_valid=1.
- Load, IDLE->SHIFT: on an edge with en=1 and the holding register full:
  - shift register <= hold; J <= first bit; bit counter <= WIDTH-1; hold becomes empty.
  - Latency: a word accepted at edge k appears on J from edge k+1 at the earliest, if en=1.
- SHIFT, en=1:
  - If counter != 0: J <= next bit; counter decrements.
  - If counter == 0 (last bit currently on J) and hold is full: load as above, stay in SHIFT. Back-to-back words yield continuous J_valid with no gap bit.
  - If counter == 0 and hold is empty: go to IDLE; J <= 0, J_valid <= 0.
- word_done = 1 while the last bit of a word is on J and J_valid=1. words_sent increments on the edge that retires that bit (en=1).
- en=0: shifter, J, J_valid, counter and word_done are all frozen. word_done remains asserted if frozen on a last bit, but words_sent increments only once.
- Simultaneous accept and hold-to-shifter transfer on the same edge: the transfer takes the old hold contents; the new word occupies hold. din_ready therefore stays 1 across the transfer only if hold was emptied. The registered din_ready is 0 that cycle, so this case cannot occur in practice; RTL must still be correct if it does.
- Reset mid-word: the partial word and the holding register are discarded, and all outputs return to reset values immediately.
- Downstream detectors must gate on J_valid. Idle J is defined as 0.

Optional Feature:
- Macro SERIAL_PATTERN_PARITY_EN.
- When defined:
  - After the last data bit, one extra SHIFT cycle emits even parity of the word on J with J_valid=1.
  - word_done and the words_sent increment move to the parity cycle.
  - A back-to-back load occurs after the parity bit.
- When undefined: no parity bit, and behaviour is exactly as above.

Test Plan:
- Reset: hold rst=0 mid-stream -> J=0, J_valid=0, din_ready=1, busy=0, words_sent=0 asynchronously, before the next clk edge.
- Single word: WIDTH=8, MSB_FIRST=1, din=8'b1001_0000 accepted at edge k, en=1 -> J = 1,0,0,1,0,0,0,0 on cycles k+1..k+8; word_done only at k+8; J_valid drops at k+9; words_sent=1.
- Back-to-back: words 8'hA5 then 8'h3C presented continuously -> 16 consecutive J_valid cycles with no gap. din_ready=0 while hold is full. A downstream 10010 detector sees exactly the concatenated bit stream.
- Stall: en=0 for 3 cycles during bit 4 of 8'hF0 -> J and the counter frozen; the remaining bits resume unchanged; total of 11 valid cycles; words_sent=1.
- Reset mid-word: rst=0 after bit 3 of 8'hFF, with a word waiting in hold -> after release, J_valid=0 and din_ready=1; the next word accepted serializes cleanly.
- Parity (SERIAL_PATTERN_PARITY_EN): din=8'b1001_0000 -> 9 valid bits, the last bit=0 (even parity); din=8'h01 -> parity bit=1; word_done on the 9th bit.
